// File: rtl/npu_seq.sv
// ============================================================================
// Module   : npu_seq
// Brief    : Row sequencer for the NPU systolic array. It issues weight or
//            activation rows, uses credits to gate issue, and buffers results.
// Option   : NPU_SEQ_CYCLE_CNT_EN builds the saturating busy-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module npu_seq #(
    parameter int ARRAY_N   = 4,
    parameter int OUT_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   seq_start,
    input  logic [1:0]             seq_mode,
    input  logic [31:0]            seq_total_rows,
    output logic                   seq_busy,
    output logic                   seq_done,
    output logic [31:0]            seq_cycles,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ARRAY_N*8-1:0]   in_data,
    output logic                   arr_load_weight,
    output logic                   arr_valid_in,
    output logic [ARRAY_N*8-1:0]   arr_x_in,
    input  logic                   arr_valid_out,
    input  logic [ARRAY_N*32-1:0]  arr_y_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ARRAY_N*32-1:0]  out_data
);

    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_S = (CW+1)'(OUT_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WLOAD = 2'd1,
        S_EXEC  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e                  state_q;
    logic [31:0]             rows_q;
    logic                    done_q;
    logic                    avin_q;
    logic                    lw_q;
    logic [ARRAY_N*8-1:0]    x_q;
    logic [CW-1:0]           inflight_q;
    logic [CW-1:0]           count_q;
    logic [PW-1:0]           wr_ptr_q;
    logic [PW-1:0]           rd_ptr_q;
    logic [ARRAY_N*32-1:0]   mem_q [OUT_DEPTH];

    logic                    in_ready_d;
    logic                    in_hs;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic [CW:0]             occupancy;

    // Credits cover both results still inside the array and results buffered.
    assign occupancy = {1'b0, inflight_q} + {1'b0, count_q};

    always_comb begin
        in_ready_d = 1'b0;
        case (state_q)
            S_WLOAD: in_ready_d = 1'b1;
            S_EXEC:  in_ready_d = (occupancy < DEPTH_S);
            default: in_ready_d = 1'b0;
        endcase
    end

    assign in_hs = in_valid & in_ready_d;
    assign issue = in_hs & (state_q == S_EXEC);
    assign push  = arr_valid_out & (inflight_q != '0);
    assign out_valid = (count_q != '0);
    assign pop   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rows_q  <= '0;
            done_q  <= 1'b0;
            avin_q  <= 1'b0;
            lw_q    <= 1'b0;
            x_q     <= '0;
        end else begin
            avin_q <= 1'b0;
            lw_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (seq_start) begin
                        done_q <= 1'b0;
                        case (seq_mode)
                            2'd0: begin
                                rows_q  <= 32'(ARRAY_N);
                                state_q <= S_WLOAD;
                            end
                            2'd1: begin
                                if (seq_total_rows != 32'd0) begin
                                    rows_q  <= seq_total_rows;
                                    state_q <= S_EXEC;
                                end else begin
                                    done_q <= 1'b1;
                                end
                            end
                            default: done_q <= 1'b1;
                        endcase
                    end
                end
                S_WLOAD: begin
                    if (in_hs) begin
                        avin_q <= 1'b1;
                        lw_q   <= 1'b1;
                        x_q    <= in_data;
                        rows_q <= rows_q - 32'd1;
                        if (rows_q == 32'd1) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (in_hs) begin
                        avin_q <= 1'b1;
                        x_q    <= in_data;
                        rows_q <= rows_q - 32'd1;
                        if (rows_q == 32'd1) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                default: begin
                    if ((inflight_q == '0) && (count_q == '0)) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Returns with no outstanding credit are strays and are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else begin
            case ({issue, push})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= arr_y_out;
        end
    end

    assign out_data        = out_valid ? mem_q[rd_ptr_q] : '0;
    assign in_ready        = in_ready_d;
    assign seq_busy        = (state_q != S_IDLE);
    assign seq_done        = done_q;
    assign arr_valid_in    = avin_q;
    assign arr_load_weight = lw_q;
    assign arr_x_in        = x_q;

`ifdef NPU_SEQ_CYCLE_CNT_EN
    logic [31:0] cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_q <= '0;
        end else if ((state_q == S_IDLE) && seq_start) begin
            cycles_q <= '0;
        end else if ((state_q != S_IDLE) && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign seq_cycles = cycles_q;
`else
    assign seq_cycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_npu_seq.sv
// Directed testbench for npu_seq with a fixed-latency (3 cycle) array model.
`default_nettype none

module tb_npu_seq;

    logic         clk;
    logic         rst_n;
    logic         seq_start;
    logic [1:0]   seq_mode;
    logic [31:0]  seq_total_rows;
    logic         seq_busy;
    logic         seq_done;
    logic [31:0]  seq_cycles;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         arr_load_weight;
    logic         arr_valid_in;
    logic [31:0]  arr_x_in;
    logic         arr_valid_out;
    logic [127:0] arr_y_out;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    logic         stray_v;
    logic         p0, p1, p2;
    logic [127:0] d0, d1, d2;

    int tests_run;
    int tests_failed;

    // Results collected by run_exec
    logic [127:0] rx [0:15];
    int rx_n, stalls, busy_cnt, avin_cnt, lw_cnt, sent_at_hold;
    logic ir_at_hold, done_after_start, done_at_end, done_final;

    npu_seq #(.ARRAY_N(4), .OUT_DEPTH(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .seq_start       (seq_start),
        .seq_mode        (seq_mode),
        .seq_total_rows  (seq_total_rows),
        .seq_busy        (seq_busy),
        .seq_done        (seq_done),
        .seq_cycles      (seq_cycles),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .arr_load_weight (arr_load_weight),
        .arr_valid_in    (arr_valid_in),
        .arr_x_in        (arr_x_in),
        .arr_valid_out   (arr_valid_out),
        .arr_y_out       (arr_y_out),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] arr_fn(input logic [31:0] x);
        logic [127:0] y;
        for (int l = 0; l < 4; l++) y[l*32 +: 32] = 32'(x[l*8 +: 8]) * 32'd3 + 32'd1;
        return y;
    endfunction

    function automatic logic [31:0] row(input int r);
        logic [31:0] v;
        for (int l = 0; l < 4; l++) v[l*8 +: 8] = 8'(r * 4 + l + 'h11);
        return v;
    endfunction

    // Array model: activations return after 3 cycles, weight loads return nothing.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0 <= 1'b0; p1 <= 1'b0; p2 <= 1'b0;
            d0 <= '0;   d1 <= '0;   d2 <= '0;
        end else begin
            p0 <= arr_valid_in & ~arr_load_weight;
            d0 <= arr_fn(arr_x_in);
            p1 <= p0; d1 <= d0;
            p2 <= p1; d2 <= d1;
        end
    end
    assign arr_valid_out = p2 | stray_v;
    assign arr_y_out     = stray_v ? 128'hDEAD : d2;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_exec(input int n, input int hold, input int inj);
        rx_n = 0; stalls = 0; busy_cnt = 0; avin_cnt = 0; lw_cnt = 0;
        sent_at_hold = -1; ir_at_hold = 1'bx;
        seq_mode = 2'd1; seq_total_rows = 32'(n); seq_start = 1'b1;
        step;
        seq_start = 1'b0;
        done_after_start = seq_done;
        begin
            int sent;
            sent = 0;
            for (int cyc = 0; cyc < 500 && rx_n < n; cyc++) begin
                if (seq_busy) busy_cnt++;
                if (arr_valid_in) avin_cnt++;
                if (arr_load_weight) lw_cnt++;
                seq_start      = (cyc == inj);
                seq_mode       = (cyc == inj) ? 2'd0 : 2'd1;
                seq_total_rows = (cyc == inj) ? 32'd3 : 32'(n);
                in_valid  = (sent < n);
                in_data   = row(sent);
                out_ready = (cyc >= hold);
                if (cyc == hold) begin
                    sent_at_hold = sent;
                    ir_at_hold   = in_ready;
                end
                if (in_valid && !in_ready) stalls++;
                if (in_valid && in_ready) sent++;
                if (out_valid && out_ready) begin
                    rx[rx_n] = out_data;
                    rx_n++;
                end
                step;
            end
        end
        in_valid = 1'b0; seq_start = 1'b0; seq_mode = 2'd1;
        done_at_end = seq_done;
        for (int k = 0; k < 20 && seq_busy; k++) begin
            busy_cnt++;
            step;
        end
        done_final = seq_done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; seq_start = 1'b0; seq_mode = 2'd0; seq_total_rows = 32'd0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stray_v = 1'b0;
        step; step;
        tests_run++;
        if ({seq_busy, seq_done, in_ready, arr_load_weight, arr_valid_in, out_valid} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {seq_busy, seq_done, in_ready, arr_load_weight, arr_valid_in, out_valid});
        end
        tests_run++;
        if (arr_x_in !== 32'd0 || out_data !== 128'd0 || seq_cycles !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_data: x=%h out=%h cyc=%h expected zeros", arr_x_in, out_data, seq_cycles);
        end
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_weight_load;
        logic [31:0] w [0:3];
        w[0] = 32'h04030201; w[1] = 32'h08070605; w[2] = 32'h0C0B0A09; w[3] = 32'h100F0E0D;
        seq_mode = 2'd0; seq_start = 1'b1;
        step;
        seq_start = 1'b0;
        tests_run++;
        if (seq_busy !== 1'b1 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL wload_start: busy=%b in_ready=%b expected 1 1", seq_busy, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = w[i];
            step;
            tests_run++;
            if (arr_valid_in !== 1'b1 || arr_load_weight !== 1'b1 || arr_x_in !== w[i]) begin
                tests_failed++;
                $display("FAIL wload_row%0d: v=%b lw=%b x=%h expected 1 1 %h",
                         i, arr_valid_in, arr_load_weight, arr_x_in, w[i]);
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (seq_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL wload_done: got %b expected 1", seq_done);
        end
        step;
        tests_run++;
        if (seq_busy !== 1'b0 || arr_valid_in !== 1'b0 || seq_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL wload_end: busy=%b v=%b done=%b expected 0 0 1", seq_busy, arr_valid_in, seq_done);
        end
    endtask

    task automatic test_exec_stream;
        run_exec(10, 0, -1);
        tests_run++;
        if (done_after_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_done_clear: got %b expected 0", done_after_start);
        end
        tests_run++;
        if (rx_n != 10 || stalls != 0) begin
            tests_failed++;
            $display("FAIL stream_count: rx=%0d stalls=%0d expected 10 0", rx_n, stalls);
        end
        for (int i = 0; i < rx_n; i++) begin
            tests_run++;
            if (rx[i] !== arr_fn(row(i))) begin
                tests_failed++;
                $display("FAIL stream_data%0d: got %h expected %h", i, rx[i], arr_fn(row(i)));
            end
        end
        tests_run++;
        if (done_at_end !== 1'b0 || done_final !== 1'b1 || seq_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_done: at_end=%b final=%b busy=%b expected 0 1 0", done_at_end, done_final, seq_busy);
        end
        tests_run++;
`ifdef NPU_SEQ_CYCLE_CNT_EN
        if (seq_cycles !== 32'(busy_cnt)) begin
            tests_failed++;
            $display("FAIL cycle_count: got %0d expected %0d", seq_cycles, busy_cnt);
        end
`else
        if (seq_cycles !== 32'd0) begin
            tests_failed++;
            $display("FAIL cycle_count_off: got %0d expected 0", seq_cycles);
        end
`endif
    endtask

    task automatic test_backpressure;
        run_exec(10, 40, -1);
        tests_run++;
        if (sent_at_hold != 8 || ir_at_hold !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_credit: sent=%0d in_ready=%b expected 8 0", sent_at_hold, ir_at_hold);
        end
        tests_run++;
        if (rx_n != 10 || done_final !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_count: rx=%0d done=%b expected 10 1", rx_n, done_final);
        end
        for (int i = 0; i < rx_n; i++) begin
            tests_run++;
            if (rx[i] !== arr_fn(row(i))) begin
                tests_failed++;
                $display("FAIL bp_data%0d: got %h expected %h", i, rx[i], arr_fn(row(i)));
            end
        end
    endtask

    task automatic test_boundaries;
        rst_n = 1'b0; step; rst_n = 1'b1; step;
        seq_mode = 2'd1; seq_total_rows = 32'd0; seq_start = 1'b1;
        step;
        seq_start = 1'b0;
        tests_run++;
        if (seq_busy !== 1'b0 || seq_done !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_rows: busy=%b done=%b in_ready=%b expected 0 1 0", seq_busy, seq_done, in_ready);
        end
        step;
        tests_run++;
        if (seq_busy !== 1'b0 || arr_valid_in !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_rows_idle: busy=%b v=%b expected 0 0", seq_busy, arr_valid_in);
        end
        seq_mode = 2'd3; seq_total_rows = 32'd5; seq_start = 1'b1; in_valid = 1'b1;
        step;
        seq_start = 1'b0;
        tests_run++;
        if (seq_busy !== 1'b0 || seq_done !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL mode3: busy=%b done=%b in_ready=%b expected 0 1 0", seq_busy, seq_done, in_ready);
        end
        step;
        in_valid = 1'b0;
        tests_run++;
        if (seq_busy !== 1'b0 || arr_valid_in !== 1'b0) begin
            tests_failed++;
            $display("FAIL mode3_idle: busy=%b v=%b expected 0 0", seq_busy, arr_valid_in);
        end
    endtask

    task automatic test_ignored_inputs;
        stray_v = 1'b1;
        step;
        stray_v = 1'b0;
        step;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_push: out_valid=%b expected 0", out_valid);
        end
        run_exec(10, 0, 3);
        tests_run++;
        if (avin_cnt != 10 || lw_cnt != 0 || rx_n != 10) begin
            tests_failed++;
            $display("FAIL start_ignored: issued=%0d weights=%0d rx=%0d expected 10 0 10", avin_cnt, lw_cnt, rx_n);
        end
        tests_run++;
        if (done_final !== 1'b1 || rx[9] !== arr_fn(row(9))) begin
            tests_failed++;
            $display("FAIL start_ignored_end: done=%b last=%h expected 1 %h", done_final, rx[9], arr_fn(row(9)));
        end
    endtask

    task automatic test_reset_mid_exec;
        seq_mode = 2'd1; seq_total_rows = 32'd10; seq_start = 1'b1; out_ready = 1'b0;
        step;
        seq_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = row(i);
            step;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step;
        tests_run++;
        if (out_valid !== 1'b1 || seq_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_exec_state: out_valid=%b busy=%b expected 1 1", out_valid, seq_busy);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({seq_busy, seq_done, in_ready, arr_load_weight, arr_valid_in, out_valid} !== 6'b0 ||
            arr_x_in !== 32'd0 || out_data !== 128'd0 || seq_cycles !== 32'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: flags=%b x=%h out=%h cyc=%h expected zeros",
                     {seq_busy, seq_done, in_ready, arr_load_weight, arr_valid_in, out_valid},
                     arr_x_in, out_data, seq_cycles);
        end
        step;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step;
        tests_run++;
        if (out_valid !== 1'b0 || seq_done !== 1'b0 || seq_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset: out_valid=%b done=%b busy=%b expected 0 0 0", out_valid, seq_done, seq_busy);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset;
        test_weight_load;
        test_exec_stream;
        test_backpressure;
        test_boundaries;
        test_ignored_inputs;
        test_reset_mid_exec;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
